multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle FSM that sequences the single shared ALU/execute datapath through FETCH,
//  DECODE, EXEC, MEM and WB for a MIPS subset.
//  - Drives the ALU function code, the ALU-B mux select and the destination-register mux select.
//  - Drives PC/IR write enables and memory requests, and counts retired instructions.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  opcode      in   6   instr[31:26], valid while ir_write or later
//  funct       in   6   instr[5:0]
//  zero        in   1   ALU result == 0 (from datapath, same cycle)
//  mem_ready   in   1   memory handshake: access completes in this cycle
//  alu_fun     out  3   001 add, 010 sub, 011 and, 100 or, 101 nor, 110 slt, 000 -> result 0
//  sel_alu     out  1   1: ALU B = sign-extended imm, 0: register rt
//  sel_reg     out  1   1: dest = rd, 0: dest = rt
//  ir_write    out  1   latch instruction register
//  pc_write    out  1   update PC
//  pc_src      out  2   00 PC+4, 01 branch target, 10 jump target
//  mem_req     out  1   memory request, held until mem_ready
//  mem_we      out  1   store (valid with mem_req)
//  reg_write   out  1   register-file write
//  mem_to_reg  out  1   writeback data from memory, not from the ALU
//  illegal     out  1   sticky: unsupported opcode/funct decoded
//  retired     out  CNT_W  instructions completed
// BEHAVIOUR
//  Reset (rst_n=0, async): state=FETCH; every output 0; retired=0; opcode/funct latches cleared.
//  Outputs are Moore decodes of the state and the latched op/funct; the exceptions are
//   pc_write in EXEC/beq (uses zero) and ir_write/pc_write in FETCH (use mem_ready).
//  The opcode/funct latches capture on the DECODE entry cycle; later input changes are ignored.
//  FETCH : mem_req=1, mem_we=0. Stay while !mem_ready.
//   On mem_ready: ir_write=1, pc_write=1, pc_src=00 -> DECODE.
//  DECODE: 1 cycle; decode the latched fields.
//   Legal: R(op 00, funct 20/22/24/25/27/2A = add/sub/and/or/nor/slt), lw 23, sw 2B, beq 04,
//   addi 08, j 02 (all hex) -> EXEC. Anything else -> HALT.
//  EXEC  : R: alu_fun from funct, sel_alu=0 -> WB. addi: add, sel_alu=1 -> WB.
//   lw/sw: add, sel_alu=1 -> MEM.
//   beq: sub, sel_alu=0, pc_src=01, pc_write=zero -> FETCH; retired++.
//   j: pc_write=1, pc_src=10, alu_fun=000 -> FETCH; retired++.
//  MEM   : mem_req=1, mem_we=(sw). Hold all outputs while !mem_ready.
//   On ready: lw -> WB; sw -> FETCH and retired++.
//  WB    : reg_write=1 for 1 cycle; sel_reg=1 for R, else 0; mem_to_reg=(lw). -> FETCH; retired++.
//  HALT  : illegal=1; all other outputs 0; stays until reset.
//  Latency with zero-wait memory: j/beq 3, R/addi/sw 4, lw 5 cycles.
//   Each wait cycle adds 1 in FETCH/MEM.
//  mem_ready while mem_req=0 is ignored.
//   A mem_ready in the final FETCH/MEM cycle is not carried over to the next access.
//  retired wraps from all-ones to 0 with no flag.
//  Reset asserted mid-access drops mem_req asynchronously; the partial instruction is not retired.
// STRUCTURE
//  Shared package ctrl_defs: opcode/funct constants, ALU_FUN encodings, state encoding
//   (FETCH, DECODE, EXEC, MEM, WB, HALT), pc_src encodings.
//  Sub-module alu_decoder: combinational {op,funct} -> {alu_fun, sel_alu, sel_reg, legal}.
//   Shared with the datapath tests.
// TESTING
//  add (op00 f20), mem_ready always 1 -> FETCH,DECODE,EXEC(alu_fun=001,sel_alu=0),WB(sel_reg=1,
//   reg_write=1); retired 0->1 after 4 cycles.
//  lw (op23), mem_ready low 2 cycles in MEM -> mem_req held 3 cycles, mem_we=0;
//   WB has mem_to_reg=1, sel_reg=0; total 7 cycles.
//  beq (op04) with zero=1 then zero=0 -> EXEC alu_fun=010, pc_src=01; pc_write=1 then 0;
//   both retire in 3 cycles.
//  Illegal op 3F -> HALT after DECODE, illegal=1 sticky, mem_req stays 0 over 20 cycles;
//   rst_n pulse clears.
//  rst_n low during MEM of sw -> outputs 0 in the same cycle; after release FETCH;
//   retired unchanged (0).
//  CNT_W=4, 16 j instructions -> retired wraps 15 -> 0.

Source files
------------

// File: rtl/ctrl_defs.sv
// rtl/ctrl_defs.sv - shared opcode/funct constants and control encodings
package ctrl_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ZERO = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_SLT  = 3'b110
  } alu_fun_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational {op,funct} to ALU controls and legality
module alu_decoder
  import ctrl_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_fun,
  output logic       sel_alu,
  output logic       sel_reg,
  output logic       legal
);

  // Decode the instruction class; anything not listed stays illegal
  always_comb begin
    alu_fun = ALU_ZERO;
    sel_alu = 1'b0;
    sel_reg = 1'b0;
    legal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        sel_reg = 1'b1;
        legal   = 1'b1;
        case (funct)
          FN_ADD:  alu_fun = ALU_ADD;
          FN_SUB:  alu_fun = ALU_SUB;
          FN_AND:  alu_fun = ALU_AND;
          FN_OR:   alu_fun = ALU_OR;
          FN_NOR:  alu_fun = ALU_NOR;
          FN_SLT:  alu_fun = ALU_SLT;
          default: legal   = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        alu_fun = ALU_ADD;
        sel_alu = 1'b1;
        legal   = 1'b1;
      end
      OP_BEQ: begin
        alu_fun = ALU_SUB;
        legal   = 1'b1;
      end
      OP_J: begin
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB controller
module multicycle_control
  import ctrl_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       alu_fun,
  output logic             sel_alu,
  output logic             sel_reg,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [2:0] dec_alu_fun;
  logic       dec_sel_alu;
  logic       dec_sel_reg;
  logic       dec_legal;

  alu_decoder u_alu_decoder (
    .op      (op_q),
    .funct   (funct_q),
    .alu_fun (dec_alu_fun),
    .sel_alu (dec_sel_alu),
    .sel_reg (dec_sel_reg),
    .legal   (dec_legal)
  );

  // State, latched instruction fields and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      funct_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      retired_q <= retired_d;
    end
  end

  // Next state and control outputs; outputs are forced low while reset is held
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    retired_d  = retired_q;
    alu_fun    = ALU_ZERO;
    sel_alu    = 1'b0;
    sel_reg    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          op_d     = opcode;
          funct_d  = funct;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = dec_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        alu_fun = dec_alu_fun;
        sel_alu = dec_sel_alu;
        case (op_q)
          OP_BEQ: begin
            pc_src    = PC_BRANCH;
            pc_write  = zero;
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_ONE;
          end
          OP_J: begin
            pc_src    = PC_JUMP;
            pc_write  = 1'b1;
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_ONE;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_ONE;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        sel_reg    = dec_sel_reg;
        mem_to_reg = (op_q == OP_LW);
        state_d    = S_FETCH;
        retired_d  = retired_q + CNT_ONE;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      alu_fun    = ALU_ZERO;
      sel_alu    = 1'b0;
      sel_reg    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_PLUS4;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign retired = retired_q;

endmodule
